// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined bitwise logic unit with an XOR accumulator,
// valid/ready handshake on both sides and registered zero/parity flags.
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             parity,
  output logic [WIDTH-1:0] acc
);

  localparam int LAST = STAGES - 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  acc_d;
  logic [WIDTH-1:0]  acc_eff;
  logic [WIDTH-1:0]  result;
  logic              zero_q;
  logic              parity_q;
  logic              accept;
  logic              tail_full;

  // Bitwise operation table; XACC folds the effective accumulator in.
  function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0] f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [WIDTH-1:0] m);
    case (f)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_XNOR: return ~(x ^ y);
      OP_NAND: return ~(x & y);
      OP_NOR:  return ~(x | y);
      OP_NOT:  return ~x;
      default: return m ^ x ^ y;
    endcase
  endfunction

  // Backward ready: stage i may load unless it and every stage after it are
  // full while the last stage is not being drained.
  always_comb begin
    tail_full = 1'b1;
    load      = '0;
    for (int i = LAST; i >= 0; i--) begin
      tail_full = tail_full && v_q[i];
      load[i]   = out_ready || !tail_full;
    end
  end

  // Operand side: compute the result at accept and the next accumulator.
  // A clear in the same cycle makes the XACC see a zero accumulator.
  always_comb begin
    accept  = in_valid && load[0];
    acc_eff = acc_clr ? '0 : acc_q;
    result  = logic_fn(op, a, b, acc_eff);
    acc_d   = acc_eff;
    if (accept && (op == 3'b111)) begin
      acc_d = result;
    end
  end

  // Stage inputs: stage 0 takes the fresh result, others take their predecessor.
  always_comb begin
    v_d[0]    = in_valid;
    data_d[0] = result;
    for (int i = 1; i < STAGES; i++) begin
      v_d[i]    = v_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  // Pipeline, flag and accumulator registers; reset flushes all in-flight beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q      <= '0;
      acc_q    <= '0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      for (int i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          v_q[i] <= v_d[i];
          if (v_d[i]) begin
            data_q[i] <= data_d[i];
          end
        end
      end
      if (load[LAST] && v_d[LAST]) begin
        zero_q   <= (data_d[LAST] == '0);
        parity_q <= ^data_d[LAST];
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[LAST];
  assign out       = data_q[LAST];
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed checks on a 32-bit/2-stage instance and
// a randomized sweep of six width/depth configurations against a queue model.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] r;
    int          c;
    bit          l;
  } beat_t;

  // Main instance signals
  logic        rst;
  logic        in_valid, in_ready, acc_clr, out_valid, out_ready, zero, parity;
  logic [2:0]  op;
  logic [31:0] a, b, out, acc;

  logic_unit_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zero(zero), .parity(parity), .acc(acc)
  );

  // Sweep shared stimulus
  logic        sw_rst, sw_en, sw_lat, sw_done;
  logic        sw_in_valid, sw_acc_clr, sw_out_ready;
  logic [2:0]  sw_op;
  logic [63:0] sw_a, sw_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] req);
    nchk++;
    assert (got === req) else begin
      nfail++;
      $error("FAIL %s: got %h, expected %h", tag, got, req);
    end
  endtask

  // Reference: the op table straight from the operation list.
  function automatic logic [63:0] ref_op(input logic [2:0] f, input logic [63:0] x,
                                         input logic [63:0] y, input logic [63:0] m);
    case (f)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x ^ y);
      3'd4: return ~(x & y);
      3'd5: return ~(x | y);
      3'd6: return ~x;
      default: return m ^ x ^ y;
    endcase
  endfunction

  for (genvar g = 0; g < 6; g++) begin : sw
    localparam int W = (g < 2) ? 1 : ((g < 4) ? 8 : 64);
    localparam int S = (g % 2 == 0) ? 1 : 4;
    logic         irdy, ov, zf, pf;
    logic [W-1:0] o, ac;
    logic [W-1:0] macc = '0;
    beat_t        q[$];

    logic_unit_pipe #(.WIDTH(W), .STAGES(S)) u (
      .clk(clk), .rst(sw_rst), .in_valid(sw_in_valid), .in_ready(irdy),
      .op(sw_op), .a(sw_a[W-1:0]), .b(sw_b[W-1:0]), .acc_clr(sw_acc_clr),
      .out_valid(ov), .out_ready(sw_out_ready), .out(o), .zero(zf),
      .parity(pf), .acc(ac)
    );

    always @(negedge clk) begin
      if (sw_en) begin
        automatic beat_t       e;
        automatic logic [63:0] full;
        automatic logic [W-1:0] r, ae;
        check("sw_acc", 64'(ac), 64'(macc));
        if (ov && sw_out_ready) begin
          if (q.size() == 0) begin
            check("sw_spurious_beat", 64'(ov), 64'd0);
          end else begin
            e = q.pop_front();
            check("sw_out", 64'(o), e.r);
            check("sw_zero", 64'(zf), 64'(e.r == 64'd0));
            check("sw_parity", 64'(pf), 64'(^e.r));
            if (sw_lat && e.l) check("sw_latency", 64'(cyc - e.c), 64'(S));
          end
        end
        if (sw_in_valid && irdy) begin
          ae   = sw_acc_clr ? '0 : macc;
          full = ref_op(sw_op, sw_a, sw_b, 64'(ae));
          r    = full[W-1:0];
          e.r  = 64'(r);
          e.c  = cyc;
          e.l  = sw_lat;
          q.push_back(e);
          macc <= (sw_op == 3'd7) ? r : ae;
        end else if (sw_acc_clr) begin
          macc <= '0;
        end
      end
    end

    always @(posedge sw_done) check("sw_drain_empty", 64'(q.size()), 64'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic clr);
    in_valid = v;
    op       = o;
    a        = x;
    b        = y;
    acc_clr  = clr;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e1 [7];
    logic [31:0] bq[$];
    logic [31:0] ev;
    int nacc, ndel;
    e1 = '{32'h00F0_0034, 32'hFFF0_12FF, 32'hFF00_12CB, 32'h00FF_ED34,
           32'hFF0F_FFCB, 32'h000F_ED00, 32'h0F0F_EDCB};
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    sw_rst = 1'b1; sw_en = 1'b0; sw_lat = 1'b0; sw_done = 1'b0;
    sw_in_valid = 1'b0; sw_acc_clr = 1'b0; sw_out_ready = 1'b1;
    sw_op = 3'd0; sw_a = '0; sw_b = '0;

    // Reset state
    tick; tick;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_parity", 64'(parity), 64'd0);
    check("rst_acc", 64'(acc), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Ops 000..110 back-to-back, two-cycle latency
    drive(1'b1, 3'd0, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      tick;
      if (k >= 2 && k <= 8) begin
        check("ops_valid", 64'(out_valid), 64'd1);
        check("ops_out", 64'(out), 64'(e1[k-2]));
        check("ops_parity", 64'(parity), 64'(^e1[k-2]));
      end
      if (k == 9) check("ops_drained", 64'(out_valid), 64'd0);
      if (k < 7) op = 3'(k);
      else in_valid = 1'b0;
    end
    check("ops_acc_untouched", 64'(acc), 64'd0);

    // XACC and acc_clr
    drive(1'b1, 3'd7, 32'h1, 32'h2, 1'b0);
    tick; check("xacc1_acc", 64'(acc), 64'h3);
    drive(1'b1, 3'd7, 32'h4, 32'h0, 1'b0);
    tick; check("xacc1_out", 64'(out), 64'h3); check("xacc2_acc", 64'(acc), 64'h7);
    drive(1'b1, 3'd7, 32'h8, 32'h0, 1'b1);
    tick; check("xacc2_out", 64'(out), 64'h7); check("xacc_clr_acc", 64'(acc), 64'h8);
    drive(1'b1, 3'd0, 32'hFFFF, 32'hFFFF, 1'b0);
    tick; check("xacc_clr_out", 64'(out), 64'h8); check("and_keeps_acc", 64'(acc), 64'h8);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    tick; check("and_out", 64'(out), 64'hFFFF); check("clr_idle_acc", 64'(acc), 64'h0);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    tick; check("xacc_drained", 64'(out_valid), 64'd0);

    // Flags
    drive(1'b1, 3'd0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    tick; drive(1'b1, 3'd2, 32'h1, 32'h0, 1'b0);
    tick;
    check("flag_and_out", 64'(out), 64'd0);
    check("flag_and_zero", 64'(zero), 64'd1);
    check("flag_and_parity", 64'(parity), 64'd0);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    tick;
    check("flag_xor_out", 64'(out), 64'd1);
    check("flag_xor_zero", 64'(zero), 64'd0);
    check("flag_xor_parity", 64'(parity), 64'd1);
    tick;

    // Backpressure: 5 stalled cycles while streaming 6 beats
    nacc = 0; ndel = 0;
    for (int s = 0; s < 20; s++) begin
      out_ready = (s >= 5);
      drive(nacc < 6, 3'd2, 32'h100 + 32'(nacc), 32'h0, 1'b0);
      #1;
      if (out_valid && out_ready) begin
        if (bq.size() == 0) begin
          check("bp_extra_beat", 64'(out_valid), 64'd0);
        end else begin
          ev = bq.pop_front();
          check("bp_order", 64'(out), 64'(ev));
          ndel++;
        end
      end
      if (s == 2) check("bp_accepts_at_stall", 64'(nacc), 64'd2);
      if (s >= 2 && s < 5) begin
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_out", 64'(out), 64'h100);
      end
      if (in_valid && in_ready) begin
        bq.push_back(a ^ b);
        nacc++;
      end
      tick;
    end
    in_valid = 1'b0;
    check("bp_delivered", 64'(ndel), 64'd6);
    check("bp_queue_empty", 64'(bq.size()), 64'd0);

    // Async reset mid-stall with two beats in flight
    out_ready = 1'b0;
    drive(1'b1, 3'd7, 32'h5, 32'h2, 1'b0);
    tick; drive(1'b1, 3'd7, 32'h10, 32'h0, 1'b0);
    tick; drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    check("ar_pre_out", 64'(out), 64'h7);
    check("ar_pre_parity", 64'(parity), 64'd1);
    check("ar_pre_acc", 64'(acc), 64'h17);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_out", 64'(out), 64'd0);
    check("ar_parity", 64'(parity), 64'd0);
    check("ar_acc", 64'(acc), 64'd0);
    #1 rst = 1'b0; out_ready = 1'b1;
    #1;
    check("ar_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("ar_no_stale", 64'(out_valid), 64'd0);
    end

    // Randomized sweep over widths {1,8,64} x depths {1,4}
    sw_rst = 1'b0;
    tick;
    sw_en = 1'b1;
    for (int s = 0; s < 1200; s++) begin
      sw_lat       = (s < 400);
      sw_out_ready = (s < 400) ? 1'b1 : ($urandom_range(0, 2) != 0);
      sw_in_valid  = ($urandom_range(0, 3) != 0);
      sw_op        = 3'($urandom_range(0, 7));
      sw_a         = {$urandom, $urandom};
      sw_b         = {$urandom, $urandom};
      sw_acc_clr   = ($urandom_range(0, 15) == 0);
      tick;
    end
    sw_in_valid = 1'b0; sw_acc_clr = 1'b0; sw_out_ready = 1'b1;
    repeat (12) tick;
    sw_done = 1'b1;
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit for the ALU datapath.
- Replaces fixed-width single-function gate arrays: one instance covers AND/OR/XOR/XNOR/NAND/NOR/NOT plus an XOR-accumulate mode.
- Valid/ready handshake on both sides, configurable latency, and registered zero/parity flags for the ALU status logic.

Parameters:
- WIDTH, 32, operand/result width in bits (legal 1..64)
- STAGES, 2, pipeline depth in register stages (legal 1..4)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  unit accepts beat this cycle
- op  input  3  operation select, sampled on accept
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- acc_clr  input  1  synchronous clear of the XOR accumulator
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts result
- out  output  WIDTH  result
- zero  output  1  result is all zeros
- parity  output  1  XOR-reduction of result
- acc  output  WIDTH  current accumulator value

Behaviour:
- Accept when in_valid && in_ready; deliver when out_valid && out_ready.
- Op encoding:
  - 000 AND a&b
  - 001 OR a|b
  - 010 XOR a^b
  - 011 XNOR ~(a^b)
  - 100 NAND ~(a&b)
  - 101 NOR ~(a|b)
  - 110 NOT ~a (b ignored)
  - 111 XACC: result = acc^a^b
- Result is computed at accept and enters stage 0. Stages 1..STAGES-1 carry it forward. out/zero/parity come from the last stage register.
- Each stage i holds valid bit v[i].
  - Stage i may load when !v[i], or when stage i is unloading in the same cycle.
  - The last stage unloads on out_ready.
  - in_ready = stage-0 may load. This is a combinational backward ready chain, with no combinational in_valid -> out_valid path.
- Latency: a beat accepted at cycle N appears with out_valid=1 at cycle N+STAGES when out_ready stays 1.
- Throughput: 1 beat/cycle, no bubbles with out_ready=1.
- Stall: while out_valid && !out_ready, out/zero/parity/out_valid hold stable. Upstream stages fill bubbles. in_ready drops only when all STAGES are valid and the last stage does not unload.
- Accumulator:
  - WIDTH-bit register, updated only on an accepted XACC beat: acc <= acc^a^b.
  - Other ops never change acc.
  - acc_clr=1 sets acc to 0 at the next edge, with or without an accept.
  - acc_clr together with an accepted XACC: the operation uses acc=0, so result = a^b and acc <= a^b.
  - acc_clr has no effect on results already in flight.
- zero = (out == 0); parity = ^out. Both are registered with the last stage and are meaningful only when out_valid=1.
- Reset (asynchronous, any time, including mid-stall):
  - all v[i]=0, out_valid=0, out=0, zero=0, parity=0, acc=0.
  - in_ready=1 in the first cycle after rst deasserts.
  - In-flight beats are discarded.
- Width rules: all ops are bitwise at WIDTH bits, with no carry or sign extension.
- Undefined op encodings: none. All 8 encodings are legal.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1; a=0xF0F0_1234, b=0x0FF0_00FF; ops 000..110 back-to-back -> results 0x00F0_0034, 0xFFF0_12FF, 0xFF00_12CB, 0x00FF_ED34, 0xFF0F_FFCB, 0x000F_ED00, 0x0F0F_EDCB; each arrives 2 cycles after accept, one per cycle.
- XACC from reset:
  - (a=0x1,b=0x2) -> out=0x3, acc=0x3
  - (a=0x4,b=0x0) -> out=0x7, acc=0x7
  - acc_clr with XACC (a=0x8,b=0x0) -> out=0x8, acc=0x8
- Backpressure: out_ready=0 for 5 cycles while streaming -> in_ready falls after STAGES accepts. out holds the first result unchanged. On release, all beats emerge in order with no loss or duplication.
- Flags: AND 0xAAAA_AAAA & 0x5555_5555 -> out=0, zero=1, parity=0; XOR 0x1 ^ 0x0 -> zero=0, parity=1.
- Async reset asserted mid-stall with 2 beats in flight -> out_valid=0, out=0, acc=0 immediately without a clock edge; after release, in_ready=1 and no stale beat emerges.
- Parameter sweep WIDTH in {1,8,64} x STAGES in {1,4}, random ops and stalls vs a bitwise reference model -> exact match, latency = STAGES.
